// File: rtl/core_pkg.sv
// Shared core definitions: fetch state encoding, datapath width and PC step.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Bus-wait watchdog for the fetch unit; only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (active && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the wait cycle that brings the count to 255, so that cycle is the last one in REQ.
  assign expired = active && (count_q == 8'd254);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one bus read per fetch stage, PC update at write-back.
// Optional bus-wait timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stage_is_fetch,
  input  logic            stage_is_write_back,
  input  logic            pc_write_en,
  input  logic [XLEN-1:0] pc_write_value,
  output logic            ibus_req,
  output logic [XLEN-1:0] ibus_addr,
  input  logic            ibus_ack,
  input  logic [XLEN-1:0] ibus_rdata,
  input  logic            ibus_err,
  output logic            fetch_busy,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            timeout;

`ifdef FETCH_TIMEOUT_EN
  logic wdStart, wdActive;

  assign wdStart  = (state_q == IDLE) && stage_is_fetch && (pc_q[1:0] == 2'b00);
  assign wdActive = (state_q == REQ) && !ibus_ack && !ibus_err;

  fetch_watchdog u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wdStart),
    .active  (wdActive),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    unique case (state_q)
      IDLE: begin
        if (stage_is_fetch) begin
          if (pc_q[1:0] == 2'b00) begin
            state_d       = REQ;
            instr_valid_d = 1'b0;
          end else begin
            state_d = FAULT;
          end
        end
      end
      REQ: begin
        // An error wins over a simultaneous ack so a bad word is never latched.
        if (ibus_err) begin
          state_d = FAULT;
        end else if (ibus_ack) begin
          state_d       = DONE;
          instr_d       = ibus_rdata;
          instr_valid_d = 1'b1;
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (stage_is_write_back) begin
      pc_d = pc_write_en ? pc_write_value : pc_q + PC_INCR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign ibus_req    = (state_q == REQ);
  assign ibus_addr   = pc_q;
  assign fetch_busy  = stage_is_fetch && (state_q != DONE);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a queue of expected fetch results.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stage_is_fetch;
  logic        stage_is_write_back;
  logic        pc_write_en;
  logic [31:0] pc_write_value;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        ibus_err;
  logic        fetch_busy;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        fetch_fault;

  fetch_exp_t  expQ[$];
  logic [31:0] modelPc;
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stage_is_fetch      (stage_is_fetch),
    .stage_is_write_back (stage_is_write_back),
    .pc_write_en         (pc_write_en),
    .pc_write_value      (pc_write_value),
    .ibus_req            (ibus_req),
    .ibus_addr           (ibus_addr),
    .ibus_ack            (ibus_ack),
    .ibus_rdata          (ibus_rdata),
    .ibus_err            (ibus_err),
    .fetch_busy          (fetch_busy),
    .instr               (instr),
    .instr_valid         (instr_valid),
    .pc                  (pc),
    .fetch_fault         (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fetch, input logic wb, input logic wen,
                               input logic [31:0] wval, input logic ack, input logic err,
                               input logic [31:0] rdata);
    stage_is_fetch      = fetch;
    stage_is_write_back = wb;
    pc_write_en         = wen;
    pc_write_value      = wval;
    ibus_ack            = ack;
    ibus_err            = err;
    ibus_rdata          = rdata;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic doReset;
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelPc = RESET_PC;
    settle();
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_req", {31'b0, ibus_req}, 32'd0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
  endtask

  task automatic doFetch(input int waits, input logic [31:0] data);
    fetch_exp_t exp;
    expQ.push_back({modelPc, data});
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    settle();
    checkOutput("idle_busy", {31'b0, fetch_busy}, 32'd1);
    checkOutput("idle_req", {31'b0, ibus_req}, 32'd0);
    tick();
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) applyStimulus(1, 0, 0, 32'h0, 1, 0, data);
      else            applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'hDEAD_BEEF);
      settle();
      checkOutput("req_high", {31'b0, ibus_req}, 32'd1);
      checkOutput("req_addr", ibus_addr, expQ[0].addr);
      checkOutput("req_busy", {31'b0, fetch_busy}, 32'd1);
      tick();
    end
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    settle();
    exp = expQ.pop_front();
    checkOutput("done_busy", {31'b0, fetch_busy}, 32'd0);
    checkOutput("done_req", {31'b0, ibus_req}, 32'd0);
    checkOutput("done_instr", instr, exp.data);
    checkOutput("done_valid", {31'b0, instr_valid}, 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
  endtask

  task automatic writeBack(input logic en, input logic [31:0] val);
    applyStimulus(0, 1, en, val, 0, 0, 32'h0);
    tick();
    modelPc = en ? val : modelPc + 32'd4;
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    settle();
    checkOutput("wb_pc", pc, modelPc);
  endtask

  initial begin
    int reqCycles;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    doReset();
    checkOutput("rst_instr", instr, 32'h0);

    $display("[TB] fetch with immediate ack");
    doFetch(0, 32'h0050_0093);

    $display("[TB] redirect and delayed ack");
    writeBack(1, 32'h0000_0200);
    checkOutput("wb_instr_held", instr, 32'h0050_0093);
    doFetch(4, 32'h00A0_0113);

    // Stray ack while idle must not disturb the latched word.
    applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'hFFFF_FFFF);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    settle();
    checkOutput("stray_ack_instr", instr, 32'h00A0_0113);
    checkOutput("stray_ack_valid", {31'b0, instr_valid}, 32'd1);

    $display("[TB] pc wrap");
    writeBack(1, 32'hFFFF_FFFC);
    writeBack(0, 32'h0);
    checkOutput("wrap_pc_zero", pc, 32'h0);
    doFetch(2, 32'h0020_81B3);

    $display("[TB] simultaneous ack and error");
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    applyStimulus(1, 0, 0, 32'h0, 1, 1, 32'h1111_1111);
    tick();
    applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h2222_2222);
    settle();
    checkOutput("err_fault", {31'b0, fetch_fault}, 32'd1);
    checkOutput("err_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("err_instr", instr, 32'h0020_81B3);
    checkOutput("err_req", {31'b0, ibus_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("err_sticky", {31'b0, fetch_fault}, 32'd1);
      checkOutput("err_busy", {31'b0, fetch_busy}, 32'd1);
    end
    doReset();

    $display("[TB] misaligned pc");
    writeBack(1, 32'h0000_0202);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      settle();
      checkOutput("mis_no_req", {31'b0, ibus_req}, 32'd0);
      tick();
    end
    checkOutput("mis_fault", {31'b0, fetch_fault}, 32'd1);
    checkOutput("mis_busy", {31'b0, fetch_busy}, 32'd1);
    doReset();

    $display("[TB] reset during request");
    writeBack(1, 32'h0000_0040);
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    checkOutput("mid_req_high", {31'b0, ibus_req}, 32'd1);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 1, 0, 32'h1234_5678);
    settle();
    checkOutput("mid_req_low", {31'b0, ibus_req}, 32'd0);
    checkOutput("mid_pc", pc, RESET_PC);
    tick();
    applyStimulus(0, 0, 0, 32'h0, 0, 0, 32'h0);
    settle();
    checkOutput("late_ack_instr", instr, 32'h0);
    checkOutput("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("late_ack_fault", {31'b0, fetch_fault}, 32'd0);
    modelPc = RESET_PC;

    $display("[TB] bus never answers");
    reqCycles = 0;
    applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0);
    tick();
    while (ibus_req === 1'b1 && reqCycles < 300) begin
      reqCycles++;
      tick();
    end
`ifdef FETCH_TIMEOUT_EN
    checkOutput("timeout_cycles", reqCycles, 32'd255);
    checkOutput("timeout_fault", {31'b0, fetch_fault}, 32'd1);
`else
    checkOutput("no_timeout_cycles", reqCycles, 32'd300);
    checkOutput("no_timeout_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    doReset();

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset (SHALL be word aligned).
REQ-002 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 stage_is_fetch  input  1  sequencer is in fetch stage.
REQ-005 stage_is_write_back  input  1  sequencer is in write-back stage.
REQ-006 pc_write_en  input  1  redirect PC at write-back (branch/jump taken).
REQ-007 pc_write_value  input  32  redirect target.
REQ-008 ibus_req  output  1  instruction bus read request.
REQ-009 ibus_addr  output  32  instruction bus address.
REQ-010 ibus_ack  input  1  read data valid, completes request.
REQ-011 ibus_rdata  input  32  read data.
REQ-012 ibus_err  input  1  bus error, completes request.
REQ-013 fetch_busy  output  1  sequencer SHALL hold in fetch stage while high.
REQ-014 instr  output  32  latched instruction word.
REQ-015 instr_valid  output  1  instr holds a successfully fetched word.
REQ-016 pc  output  32  current program counter.
REQ-017 fetch_fault  output  1  sticky fault flag.

Function
REQ-018 States IDLE, REQ, DONE, FAULT; ibus_req SHALL be high exactly when state is REQ; ibus_addr SHALL equal pc, held stable throughout REQ.
REQ-019 IDLE with stage_is_fetch: pc[1:0]==0 -> REQ, clear instr_valid; pc[1:0]!=0 -> FAULT, no bus request issued.
REQ-020 REQ: ibus_err -> FAULT; else ibus_ack -> DONE, instr<=ibus_rdata, instr_valid<=1; neither -> stay REQ.
REQ-021 Simultaneous ibus_ack and ibus_err SHALL be treated as error; instr and instr_valid unchanged.
REQ-022 ibus_ack/ibus_err outside REQ SHALL be ignored.
REQ-023 DONE -> IDLE next cycle unconditionally.
REQ-024 fetch_busy = stage_is_fetch AND state != DONE (combinational); FAULT keeps fetch_busy high while stage_is_fetch, halting the core.
REQ-025 FAULT SHALL be terminal until reset; fetch_fault high while in FAULT.
REQ-026 Minimum fetch-stage occupancy 3 cycles (IDLE, REQ with same-cycle ack, DONE); each wait cycle adds one.
REQ-027 stage_is_write_back: pc<=pc_write_en ? pc_write_value : pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); instr held stable outside fetch.

Reset
REQ-028 Reset SHALL set state IDLE, pc=RESET_PC, instr=0, instr_valid=0, fetch_fault=0, ibus_req=0 on the following edge, overriding all other inputs.
REQ-029 Reset during REQ SHALL drop ibus_req next cycle; late ack SHALL be ignored.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN defined: 8-bit counter cleared on entry to REQ, increments each REQ cycle without ack/err; reaching 255 -> FAULT.
REQ-031 FETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely.

Structure
REQ-032 Shared package core_pkg SHALL hold the fetch state enum, XLEN=32, and the PC increment constant 4.
REQ-033 Timeout counter SHALL be sub-module fetch_watchdog (inputs clk, reset, start, active; output expired), instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-034 Reset, RESET_PC=0x100, fetch with ack on first REQ cycle, rdata=0x00500093 -> ibus_addr=0x100, instr=0x00500093, instr_valid=1, fetch_busy low in the 3rd cycle.
REQ-035 Ack delayed 4 cycles -> ibus_req high 5 cycles, addr stable, fetch_busy high until DONE.
REQ-036 Write-back pc_write_en=1, value=0x200 -> pc=0x200; without pc_write_en, pc=0xFFFFFFFC -> pc=0.
REQ-037 Ack and err same cycle -> FAULT, fetch_fault=1, instr_valid=0, fetch_busy stays high until reset.
REQ-038 pc_write_value=0x202 then fetch -> FAULT, ibus_req never asserted.
REQ-039 FETCH_TIMEOUT_EN, no ack -> FAULT after 255 REQ cycles; reset mid-REQ -> ibus_req low next cycle, pc=RESET_PC.
